// File: rtl/imem_program_loader.sv
// Byte-stream loader for the instruction memory: frames a 16-bit word count plus
// big-endian words into write strobes. Define IMEM_LOADER_CHECKSUM_EN to add a trailing XOR checksum byte.
module imem_program_loader #(
    parameter int unsigned MAX_WORDS = 512,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [9:0]  word_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_LAST,
        S_CHK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] n_words;
    logic [1:0]  byte_cnt;
    logic [15:0] len_full;
    logic        start_ok;
    logic        data_take;
    logic        word_end;
    logic        last_word;

    // Qualifiers use byte_valid directly (ready is 1 in these states) to keep
    // byte_ready out of the next-state feedback path.
    assign len_full  = {n_words[15:8], byte_in};
    assign start_ok  = start && (state == S_IDLE || state == S_DONE || state == S_ERROR);
    assign data_take = byte_valid && (state == S_DATA);
    assign word_end  = data_take && (byte_cnt == 2'd3);
    assign last_word = word_end && (({6'd0, word_count} + 16'd1) == n_words);

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] chk_acc;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first, so no path leaves a latch behind.
        state_nxt  = state;
        byte_ready = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        error      = 1'b0;
        unique case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = S_LEN_HI;
            end
            S_LEN_HI: begin
                byte_ready = 1'b1;
                if (byte_valid) state_nxt = S_LEN_LO;
            end
            S_LEN_LO: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    if ({16'd0, len_full} > MAX_WORDS) begin
                        state_nxt = S_ERROR;
                    end else if (len_full == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_nxt = S_CHK;
`else
                        state_nxt = S_DONE;
`endif
                    end else begin
                        state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                byte_ready = 1'b1;
                if (last_word) state_nxt = S_LAST;
            end
            // Final strobe is on the bus here; no bytes taken until it retires.
            S_LAST: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state_nxt = S_CHK;
`else
                state_nxt = S_DONE;
`endif
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
                byte_ready = 1'b1;
                if (byte_valid) state_nxt = (byte_in == chk_acc) ? S_DONE : S_ERROR;
            end
`endif
            S_DONE: begin
                busy = 1'b0;
                done = 1'b1;
                if (start) state_nxt = S_LEN_HI;
            end
            S_ERROR: begin
                busy  = 1'b0;
                error = 1'b1;
                if (start) state_nxt = S_LEN_HI;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the whole datapath is reset so a partial word can never surface as a strobe.
            n_words    <= 16'd0;
            byte_cnt   <= 2'd0;
            wr_en      <= 1'b0;
            wr_addr    <= 32'd0;
            wr_data    <= 32'd0;
            word_count <= 10'd0;
        end else begin
            wr_en <= 1'b0;
            if (start_ok) begin
                byte_cnt   <= 2'd0;
                word_count <= 10'd0;
            end
            if (byte_valid && state == S_LEN_HI) n_words[15:8] <= byte_in;
            if (byte_valid && state == S_LEN_LO) n_words[7:0]  <= byte_in;
            if (data_take) begin
                wr_data  <= {wr_data[23:0], byte_in};
                byte_cnt <= byte_cnt + 2'd1;
            end
            if (word_end) begin
                wr_en      <= 1'b1;
                wr_addr    <= BASE_ADDR + {20'd0, word_count, 2'b00};
                word_count <= word_count + 10'd1;
            end
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_acc <= 8'd0;
        end else if (start_ok) begin
            chk_acc <= 8'd0;
        end else if (data_take) begin
            chk_acc <= chk_acc ^ byte_in;
        end
    end
`endif

endmodule
